// File: rtl/suprloco_z80_memresp.sv
// Memory-side responder for the main Z80 bus.
// The responder catches each CPU memory cycle and passes it to a slow external
// store over a req/ack handshake. It holds the CPU with WAIT_n until the data
// returns or the wait times out. It ignores refresh cycles and drops writes
// into the ROM region.
module suprloco_z80_memresp #(
   parameter logic [15:0] ROM_END = 16'hBFFF,
   parameter int          TIMEOUT = 64,
   parameter int          TO_W    = 7
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic        i_MREQ_n,
   input  logic        i_RD_n,
   input  logic        i_WR_n,
   input  logic        i_RFSH_n,
   input  logic [15:0] i_ADDR,
   input  logic [7:0]  i_DO,
   output logic [7:0]  o_DI,
   output logic        o_WAIT_n,
   output logic        o_MEM_REQ,
   output logic        o_MEM_WE,
   output logic [15:0] o_MEM_ADDR,
   output logic [7:0]  o_MEM_WDATA,
   input  logic        i_MEM_ACK,
   input  logic [7:0]  i_MEM_RDATA,
   output logic        o_TIMEOUT
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

   state_t            state_r, state_s;
   logic              act_s, act_d_r, start_s;
   logic [TO_W-1:0]   cnt_r, cnt_s;
   logic [7:0]        di_r, di_s;
   logic              wait_r, wait_s;
   logic              req_r, req_s;
   logic              we_r, we_s;
   logic [15:0]       addr_r, addr_s;
   logic [7:0]        wdata_r, wdata_s;
   logic              to_r, to_s;

   // A CPU memory cycle is active when MREQ is asserted with a strobe and no refresh.
   always_comb begin
      act_s   = ~i_MREQ_n & i_RFSH_n & (~i_RD_n | ~i_WR_n);
      start_s = act_s & ~act_d_r;
   end

   // Next-state and next-output logic. A start in IDLE is the only way to begin a cycle.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      di_s    = di_r;
      wait_s  = wait_r;
      req_s   = req_r;
      we_s    = we_r;
      addr_s  = addr_r;
      wdata_s = wdata_r;
      to_s    = 1'b0;
      case (state_r)
         IDLE: begin
            if (start_s) begin
               addr_s  = i_ADDR;
               wdata_s = i_DO;
               we_s    = ~i_WR_n;
               if (~i_WR_n && (i_ADDR <= ROM_END)) begin
                  // The write targets ROM, so the CPU is not held and nothing is sent.
                  state_s = HOLD;
               end else begin
                  req_s   = 1'b1;
                  wait_s  = 1'b0;
                  cnt_s   = {TO_W{1'b0}};
                  state_s = REQ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            // An ack that arrives in the timeout cycle wins, so no timeout is flagged.
            if (i_MEM_ACK) begin
               req_s   = 1'b0;
               wait_s  = 1'b1;
               cnt_s   = {TO_W{1'b0}};
               state_s = HOLD;
               if (!we_r) begin
                  di_s = i_MEM_RDATA;
               end else begin
                  di_s = di_r;
               end
            end else if (cnt_r == TO_LAST) begin
               req_s   = 1'b0;
               wait_s  = 1'b1;
               to_s    = 1'b1;
               cnt_s   = {TO_W{1'b0}};
               state_s = HOLD;
               if (!we_r) begin
                  di_s = 8'hFF;
               end else begin
                  di_s = di_r;
               end
            end else begin
               cnt_s   = cnt_r + TO_W'(1);
               state_s = REQ;
            end
         end
         HOLD: begin
            // Stay here until the CPU ends its cycle. act_d stops the same cycle from restarting.
            if (!act_s) begin
               state_s = IDLE;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
            req_s   = 1'b0;
            wait_s  = 1'b1;
            cnt_s   = {TO_W{1'b0}};
         end
      endcase
   end

   // State and output registers with a synchronous reset that overrides everything.
   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_r <= IDLE;
         act_d_r <= 1'b0;
         cnt_r   <= {TO_W{1'b0}};
         di_r    <= 8'hFF;
         wait_r  <= 1'b1;
         req_r   <= 1'b0;
         we_r    <= 1'b0;
         addr_r  <= 16'h0000;
         wdata_r <= 8'h00;
         to_r    <= 1'b0;
      end else begin
         state_r <= state_s;
         act_d_r <= act_s;
         cnt_r   <= cnt_s;
         di_r    <= di_s;
         wait_r  <= wait_s;
         req_r   <= req_s;
         we_r    <= we_s;
         addr_r  <= addr_s;
         wdata_r <= wdata_s;
         to_r    <= to_s;
      end
   end

   assign o_DI        = di_r;
   assign o_WAIT_n    = wait_r;
   assign o_MEM_REQ   = req_r;
   assign o_MEM_WE    = we_r;
   assign o_MEM_ADDR  = addr_r;
   assign o_MEM_WDATA = wdata_r;
   assign o_TIMEOUT   = to_r;

endmodule

// File: tb/tb_suprloco_z80_memresp.sv
// Self-checking bench for suprloco_z80_memresp. It uses a transaction-level model.
// For each CPU cycle the model predicts how many clocks WAIT_n stays low,
// whether a timeout is flagged, and the resulting o_DI.
module tb_suprloco_z80_memresp;

   localparam logic [15:0] ROM_END_TB = 16'hBFFF;
   localparam int          TIMEOUT_TB = 64;
   localparam int          NO_ACK     = 1000;

   logic        clk = 1'b0;
   logic        rst;
   logic        mreq_n, rd_n, wr_n, rfsh_n;
   logic [15:0] addr;
   logic [7:0]  dout;
   logic [7:0]  di;
   logic        wait_n;
   logic        mem_req, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_ack;
   logic [7:0]  mem_rdata;
   logic        timeout;

   int          checks = 0;
   int          failures = 0;
   logic [7:0]  last_di;

   suprloco_z80_memresp #(
      .ROM_END (16'hBFFF),
      .TIMEOUT (64),
      .TO_W    (7)
   ) dut (
      .i_CLK       (clk),
      .i_RST       (rst),
      .i_MREQ_n    (mreq_n),
      .i_RD_n      (rd_n),
      .i_WR_n      (wr_n),
      .i_RFSH_n    (rfsh_n),
      .i_ADDR      (addr),
      .i_DO        (dout),
      .o_DI        (di),
      .o_WAIT_n    (wait_n),
      .o_MEM_REQ   (mem_req),
      .o_MEM_WE    (mem_we),
      .o_MEM_ADDR  (mem_addr),
      .o_MEM_WDATA (mem_wdata),
      .i_MEM_ACK   (mem_ack),
      .i_MEM_RDATA (mem_rdata),
      .o_TIMEOUT   (timeout)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_di"},    32'(di),        32'h00FF);
      check({tag, "_wait"},  32'(wait_n),    32'h1);
      check({tag, "_req"},   32'(mem_req),   32'h0);
      check({tag, "_we"},    32'(mem_we),    32'h0);
      check({tag, "_addr"},  32'(mem_addr),  32'h0);
      check({tag, "_wdata"}, 32'(mem_wdata), 32'h0);
      check({tag, "_to"},    32'(timeout),   32'h0);
   endtask

   // One complete CPU memory cycle. An ack is presented in REQ cycle number
   // 'delay', counting from 0. Any delay of TIMEOUT or more means no ack.
   // The CPU releases its strobes in REQ cycle 'abort_at'; pass -1 for never.
   task automatic cpu_cycle(input bit wr, input logic [15:0] a, input logic [7:0] d,
                            input int delay, input logic [7:0] rdata, input int abort_at);
      bit rom;
      bit timed;
      int exp_lows;
      int lows;
      int to_pulses;
      rom      = wr && (a <= ROM_END_TB);
      timed    = !rom && (delay >= TIMEOUT_TB);
      exp_lows = timed ? TIMEOUT_TB : delay + 1;
      mreq_n = 1'b0; rfsh_n = 1'b1; rd_n = wr; wr_n = !wr; addr = a; dout = d;
      tick;
      if (rom) begin
         for (int i = 0; i < 3; i++) begin
            check("rom_no_req", 32'(mem_req), 32'h0);
            check("rom_wait",   32'(wait_n),  32'h1);
            tick;
         end
      end else begin
         check("start_req",  32'(mem_req),  32'h1);
         check("start_wait", 32'(wait_n),   32'h0);
         check("start_we",   32'(mem_we),   32'(wr));
         check("start_addr", 32'(mem_addr), 32'(a));
         if (wr) check("start_wdata", 32'(mem_wdata), 32'(d));
         lows = 1;
         to_pulses = 0;
         for (int k = 0; k < 200; k++) begin
            if (k == abort_at) begin
               mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
            end
            if (k == delay) begin
               mem_ack = 1'b1; mem_rdata = rdata;
            end
            tick;
            mem_ack = 1'b0;
            mem_rdata = 8'($urandom);
            to_pulses += int'(timeout);
            if (wait_n) break;
            lows++;
            check("req_held",  32'(mem_req), 32'h1);
            check("di_stable", 32'(di),      32'(last_di));
         end
         check("wait_len",      32'(lows),      32'(exp_lows));
         check("req_drop",      32'(mem_req),   32'h0);
         check("timeout_flag",  32'(timeout),   32'(timed));
         check("timeout_count", 32'(to_pulses), 32'(timed));
         if (!wr) last_di = timed ? 8'hFF : rdata;
      end
      check("di_result", 32'(di), 32'(last_di));
      mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
      tick;
      check("end_to_clear", 32'(timeout), 32'h0);
      check("end_wait",     32'(wait_n),  32'h1);
      check("end_req",      32'(mem_req), 32'h0);
      tick;
      check("end_di", 32'(di), 32'(last_di));
   endtask

   initial begin
      bit          wr;
      int          dly;
      int          ab;
      logic [15:0] ra;
      rst = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1; rfsh_n = 1'b1;
      addr = 16'h0000; dout = 8'h00; mem_ack = 1'b0; mem_rdata = 8'h00;
      last_di = 8'hFF;
      tick; tick;
      check_reset_values("reset");
      rst = 1'b0;
      tick;

      // Read with ack after 5 clocks, then write with ack after 2 clocks.
      cpu_cycle(1'b0, 16'hC123, 8'h00, 5, 8'h5A, -1);
      cpu_cycle(1'b1, 16'hE000, 8'h3C, 2, 8'h99, -1);
      // Dropped ROM write, followed by a normal read of the same address.
      cpu_cycle(1'b1, 16'h1000, 8'h42, 0, 8'h00, -1);
      cpu_cycle(1'b0, 16'h1000, 8'h00, 0, 8'hA7, -1);
      // Timeout, ack together with timeout (ack wins), ROM boundary on both sides.
      cpu_cycle(1'b0, 16'hD000, 8'h00, NO_ACK, 8'h00, -1);
      cpu_cycle(1'b0, 16'hD001, 8'h00, TIMEOUT_TB - 1, 8'h66, -1);
      cpu_cycle(1'b1, 16'hBFFF, 8'h11, 1, 8'h00, -1);
      cpu_cycle(1'b1, 16'hC000, 8'h22, 1, 8'h00, -1);
      // CPU aborts the read early; the read data is still captured.
      cpu_cycle(1'b0, 16'hF00F, 8'h00, 4, 8'hC3, 1);

      // Refresh cycle with a stray ack in IDLE.
      mreq_n = 1'b0; rfsh_n = 1'b0; rd_n = 1'b0; addr = 16'h0055;
      tick;
      mem_ack = 1'b1; mem_rdata = 8'h77;
      tick;
      mem_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("rfsh_req",  32'(mem_req), 32'h0);
         check("rfsh_wait", 32'(wait_n),  32'h1);
         check("rfsh_di",   32'(di),      32'(last_di));
         tick;
      end
      mreq_n = 1'b1; rfsh_n = 1'b1; rd_n = 1'b1;
      tick;

      // Reset 3 clocks into REQ, then a late ack after the reset is released.
      mreq_n = 1'b0; rd_n = 1'b0; addr = 16'hC555;
      tick;
      check("pre_rst_req", 32'(mem_req), 32'h1);
      tick; tick; tick;
      rst = 1'b1; mreq_n = 1'b1; rd_n = 1'b1;
      tick;
      check_reset_values("midrst");
      rst = 1'b0;
      last_di = 8'hFF;
      tick; tick;
      mem_ack = 1'b1; mem_rdata = 8'hAB;
      tick;
      mem_ack = 1'b0;
      check("late_ack_req",  32'(mem_req), 32'h0);
      check("late_ack_wait", 32'(wait_n),  32'h1);
      check("late_ack_di",   32'(di),      32'h00FF);
      tick;
      cpu_cycle(1'b0, 16'hC777, 8'h00, 3, 8'h3E, -1);

      // Randomized transactions.
      for (int n = 0; n < 16; n++) begin
         wr  = 1'($urandom_range(0, 1));
         ra  = 16'($urandom);
         dly = $urandom_range(0, 9);
         ab  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dly) : -1;
         cpu_cycle(wr, ra, 8'($urandom), dly, 8'($urandom), ab);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
